word_unpacker: RTL and testbench
================================

// Module: word_unpacker
// PURPOSE
// - Receive side of the 32-bit packed-word format {in1, in2, ZERO[15:0]}.
// - Accepts one packed word per valid/ready handshake.
// - Emits the two payload bytes as a byte stream: the MSB byte first, then the next byte.
// - Keeps a count of unpacked words.
// - Sits between a 32-bit word bus and byte-wide consumers.
// PARAMETERS
// - DATA_W  8   payload field width; word width = 4*DATA_W; zero field = 2*DATA_W.
// - CNT_W   16  width of the word counter.
// PORTS
// - clk        in   1         clock; all state changes on the rising edge.
// - rst        in   1         reset; synchronous, active-high.
// - in_valid   in   1         in_word is valid.
// - in_ready   out  1         block can take in_word this cycle.
// - in_word    in   4*DATA_W  packed word {b_hi, b_lo, zero}.
// - out_valid  out  1         out_byte is valid.
// - out_ready  in   1         consumer takes out_byte this cycle.
// - out_byte   out  DATA_W    current payload byte.
// - out_last   out  1         out_byte is the second (last) byte of its word.
// - word_cnt   out  CNT_W     number of words fully emitted, modulo 2**CNT_W.
// - zero_err   out  1         sticky error: nonzero zero field seen (see CONFIGURATION).
// BEHAVIOUR
// - Reset values (rst high at an edge): state=IDLE, out_valid=0, out_last=0, out_byte=0,
//   word_cnt=0, zero_err=0, held word cleared.
// - Reset mid-word discards the held word; no byte from it appears after reset.
// - Transfers:
//   - input transfer = in_valid && in_ready
//   - output transfer = out_valid && out_ready
// - FSM states: IDLE, HI, LO.
//   - IDLE: out_valid=0; in_ready=1. On an input transfer, register in_word and go to HI.
//   - HI: out_valid=1, out_byte=word[4*DATA_W-1 -: DATA_W], out_last=0, in_ready=0.
//     On an output transfer, go to LO. Otherwise hold, with out_byte stable.
//   - LO: out_valid=1, out_byte=word[3*DATA_W-1 -: DATA_W], out_last=1, in_ready=out_ready.
//     - On an output transfer, increment word_cnt.
//     - If an input transfer happens in the same cycle, register the new word and go to HI.
//     - Otherwise go to IDLE.
// - in_ready in LO is the only combinational in->out path: out_ready -> in_ready.
// - Latency: word accepted at edge N -> first byte valid in the cycle after edge N.
// - Throughput: 2 cycles per word with no backpressure, because LO->HI runs back-to-back.
// - Under backpressure, out_byte and out_last are stable while out_valid && !out_ready.
// - word_cnt wraps from 2**CNT_W-1 to 0 with no flag.
// - The zero field is not emitted on the byte stream.
// - in_word is don't-care when in_valid=0.
// CONFIGURATION
// - Macro: WORD_UNPACKER_ZCHK_EN
// - Defined:
//   - On an input transfer whose zero field != 0, the word is dropped.
//   - No bytes are emitted and word_cnt is unchanged; state stays or returns to IDLE.
//   - zero_err is set and held until rst.
//   - A dropped word is still acknowledged (in_ready handshake as normal).
// - Not defined: the zero field is ignored, every word is unpacked, and zero_err is tied 0.
// TESTING
// - T1 basic: rst, then in_word=32'h1020_0000 with out_ready=1
//   -> bytes 8'h10 (last=0), 8'h20 (last=1) on consecutive cycles; word_cnt=1.
// - T2 backpressure: word 32'hAB_CD_0000, out_ready=0 for 3 cycles in HI
//   -> out_byte=8'hAB held 3 cycles, then 8'hCD; in_ready=0 throughout HI.
// - T3 back-to-back: words 32'h1122_0000, 32'h3344_0000, in_valid held, out_ready=1
//   -> 11,22,33,44 on 4 consecutive cycles; second word accepted in the LO cycle of the first.
// - T4 wrap: CNT_W=2, send 5 words -> word_cnt sequence 1,2,3,0,1.
// - T5 reset mid-word: accept 32'h5566_0000, assert rst in the HI cycle
//   -> next cycle out_valid=0, word_cnt=0; byte 8'h66 never appears.
// - T6 (WORD_UNPACKER_ZCHK_EN): 32'h1020_0001 -> no output bytes, zero_err=1, word_cnt=0.
//   Then 32'h3040_0000 -> 30,40 emitted, zero_err stays 1.
//   Without the macro, the same 32'h1020_0001 yields 10,20 and zero_err=0.

Source files
------------

// File: rtl/word_unpacker.sv
// -----------------------------------------------------------------------------
// word_unpacker
//
// Receive side of the 32-bit packed-word format {b_hi, b_lo, zero}. One word is
// accepted per valid/ready handshake, and its two payload bytes are replayed
// as a byte stream, MSB byte first. A word counter tracks fully emitted words.
//
// Optional feature (macro WORD_UNPACKER_ZCHK_EN):
//   defined     - words with a nonzero zero field are acknowledged but dropped,
//                 and the sticky zero_err flag is raised until rst.
//   not defined - the zero field is ignored and zero_err is tied low.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   in_word is valid
//   in_ready   block can take in_word this cycle
//   in_word    packed word {b_hi, b_lo, zero}, 4*DATA_W bits
//   out_valid  out_byte is valid
//   out_ready  consumer takes out_byte this cycle
//   out_byte   current payload byte
//   out_last   out_byte is the second byte of its word
//   word_cnt   number of words fully emitted, modulo 2**CNT_W
//   zero_err   sticky nonzero-zero-field error
// -----------------------------------------------------------------------------
module word_unpacker #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [4*DATA_W-1:0] in_word,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   out_byte,
   output logic                out_last,
   output logic [CNT_W-1:0]    word_cnt,
   output logic                zero_err
);

   typedef enum logic [1:0] {
      IDLE,
      HI,
      LO
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [DATA_W-1:0] hi_q;
   logic [DATA_W-1:0] lo_q;
   logic              in_xfer;
   logic              zero_bad;
   logic              load;

`ifdef WORD_UNPACKER_ZCHK_EN
   assign zero_bad = |in_word[2*DATA_W-1:0];
`else
   // Zero field deliberately ignored in this build.
   logic unused_zero;
   assign unused_zero = ^in_word[2*DATA_W-1:0];
   assign zero_bad    = 1'b0;
`endif

   // LO accepts the next word only when its last byte leaves in the same
   // cycle; this is the single combinational out_ready -> in_ready path.
   assign in_ready  = (state == IDLE) || ((state == LO) && out_ready);
   assign out_valid = (state != IDLE);
   assign in_xfer   = in_valid && in_ready;
   // A dropped word completes its handshake but is never loaded.
   assign load      = in_xfer && !zero_bad;

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case statement leaves a value unassigned (no latch).
   always_comb begin
      state_nxt = state;
      out_byte  = '0;
      out_last  = 1'b0;
      case (state)
         IDLE: begin
            if (load) state_nxt = HI;
         end
         HI: begin
            out_byte = hi_q;
            if (out_ready) state_nxt = LO;
         end
         LO: begin
            out_byte = lo_q;
            out_last = 1'b1;
            if (out_ready) state_nxt = load ? HI : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         // NOTE: the held payload is plain data and would not normally need a
         // reset; it is cleared so no stale byte can surface after reset.
         hi_q     <= '0;
         lo_q     <= '0;
         word_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (load) begin
            hi_q <= in_word[4*DATA_W-1 -: DATA_W];
            lo_q <= in_word[3*DATA_W-1 -: DATA_W];
         end
         // The last byte leaving completes the word; wraps silently.
         if ((state == LO) && out_ready) word_cnt <= word_cnt + CNT_W'(1);
      end
   end

`ifdef WORD_UNPACKER_ZCHK_EN
   always_ff @(posedge clk) begin
      if (rst)                      zero_err <= 1'b0;
      else if (in_xfer && zero_bad) zero_err <= 1'b1;
   end
`else
   assign zero_err = 1'b0;
`endif

endmodule

// File: tb/tb_word_unpacker.sv
// -----------------------------------------------------------------------------
// tb_word_unpacker
//
// Self-checking bench for word_unpacker. Expected bytes are pushed to a
// scoreboard when a word handshake is driven and popped by a monitor on every
// output transfer. A second instance with CNT_W=2 shares the stimulus so that
// counter wrap is observed alongside the normal counter.
// -----------------------------------------------------------------------------
module tb_word_unpacker;

`ifdef WORD_UNPACKER_ZCHK_EN
   localparam bit ZCHK = 1'b1;
`else
   localparam bit ZCHK = 1'b0;
`endif

   typedef struct {
      logic [7:0] data;
      bit         last;
   } exp_t;

   typedef struct {
      logic [31:0] word;
      logic [7:0]  hi;
      logic [7:0]  lo;
      bit          bad;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_word;
   logic        out_ready;
   logic        in_ready, out_valid, out_last, zero_err;
   logic [7:0]  out_byte;
   logic [15:0] word_cnt;
   logic        w_in_ready, w_out_valid, w_out_last, w_zero_err;
   logic [7:0]  w_out_byte;
   logic [1:0]  w_word_cnt;

   exp_t sb[$];
   int   pop_cyc[$];
   int   checks   = 0;
   int   errors   = 0;
   int   exp_cnt  = 0;
   bit   exp_zerr = 1'b0;
   bit   bp_rand  = 1'b0;
   int   cyc      = 0;

   word_unpacker #(.DATA_W(8), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
      .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
      .out_last(out_last), .word_cnt(word_cnt), .zero_err(zero_err)
   );

   word_unpacker #(.DATA_W(8), .CNT_W(2)) u_wrap (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(w_in_ready), .in_word(in_word),
      .out_valid(w_out_valid), .out_ready(out_ready), .out_byte(w_out_byte),
      .out_last(w_out_last), .word_cnt(w_word_cnt), .zero_err(w_zero_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string msg);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", msg, cyc);
   endtask

   // ---------------------------------------------------------------- monitor
   exp_t       mon_e;
   bit         stall_q = 1'b0;
   logic [7:0] stall_byte;
   logic       stall_last;

   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         exp_cnt = 0;
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            check("stall_valid", out_valid, 1);
            check("stall_byte", out_byte, stall_byte);
            check("stall_last", out_last, stall_last);
         end
         stall_q    = out_valid && !out_ready;
         stall_byte = out_byte;
         stall_last = out_last;
         if (out_valid && out_ready) begin
            pop_cyc.push_back(cyc);
            if (sb.size() == 0) begin
               fail($sformatf("unexpected_byte: got %0h last=%0b, expected no byte", out_byte, out_last));
            end else begin
               mon_e = sb.pop_front();
               check("byte", out_byte, mon_e.data);
               check("last", out_last, mon_e.last);
               if (mon_e.last) exp_cnt++;
            end
         end
      end
   end

   // ---------------------------------------------------------------- drivers
   // All driver tasks start and end at posedge+1.
   task automatic tick();
      @(posedge clk);
      #1;
      if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      tick();
      tick();
      rst      = 1'b0;
      exp_zerr = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input logic [7:0] hi, input logic [7:0] lo,
                            input bit bad, output int waited);
      bit drop;
      drop     = bad && ZCHK;
      waited   = 0;
      in_valid = 1'b1;
      in_word  = w;
      @(negedge clk);
      while (!in_ready && waited < 40) begin
         tick();
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         fail($sformatf("accept_timeout: waited %0d cycles, required under 40", waited));
      end else if (drop) begin
         exp_zerr = 1'b1;
      end else begin
         sb.push_back('{hi, 1'b0});
         sb.push_back('{lo, 1'b1});
      end
      tick();
      in_valid = 1'b0;
      in_word  = $urandom();
   endtask

   task automatic drain();
      int n;
      n         = 0;
      bp_rand   = 1'b0;
      out_ready = 1'b1;
      tick();
      @(negedge clk);
      #1;
      while ((sb.size() != 0 || out_valid) && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 50) fail($sformatf("drain_timeout: %0d bytes still pending, required 0", sb.size()));
      check("word_cnt", word_cnt, exp_cnt[15:0]);
      check("wrap_word_cnt", w_word_cnt, exp_cnt % 4);
      check("zero_err", zero_err, exp_zerr);
      check("wrap_zero_err", w_zero_err, exp_zerr);
      tick();
   endtask

   // ---------------------------------------------------------------- test
   vec_t vecs[8];
   int   wrap_seq[5];
   int   w, w2;

   initial begin
      vecs[0] = '{32'h0102_0000, 8'h01, 8'h02, 1'b0};
      vecs[1] = '{32'hFFEE_0000, 8'hFF, 8'hEE, 1'b0};
      vecs[2] = '{32'h0000_0000, 8'h00, 8'h00, 1'b0};
      vecs[3] = '{32'h8001_0000, 8'h80, 8'h01, 1'b0};
      vecs[4] = '{32'h5AA5_1234, 8'h5A, 8'hA5, 1'b1};
      vecs[5] = '{32'h7F80_0000, 8'h7F, 8'h80, 1'b0};
      vecs[6] = '{32'hC33C_8000, 8'hC3, 8'h3C, 1'b1};
      vecs[7] = '{32'hDEAD_0000, 8'hDE, 8'hAD, 1'b0};
      wrap_seq = '{1, 2, 3, 0, 1};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_word   = '0;
      out_ready = 1'b0;

      // Reset state
      do_reset();
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_byte", out_byte, 0);
      check("rst_word_cnt", word_cnt, 0);
      check("rst_zero_err", zero_err, 0);
      check("rst_in_ready", in_ready, 1);
      tick();

      // T1 basic: first byte in the cycle after the accepting edge
      out_ready = 1'b1;
      send_word(32'h1020_0000, 8'h10, 8'h20, 1'b0, w);
      @(negedge clk);
      check("t1_hi_valid", out_valid, 1);
      check("t1_hi_byte", out_byte, 8'h10);
      check("t1_hi_last", out_last, 0);
      tick();
      @(negedge clk);
      check("t1_lo_byte", out_byte, 8'h20);
      check("t1_lo_last", out_last, 1);
      tick();
      @(negedge clk);
      check("t1_idle_valid", out_valid, 0);
      drain();

      // T2 backpressure in HI
      out_ready = 1'b0;
      send_word(32'hABCD_0000, 8'hAB, 8'hCD, 1'b0, w);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t2_hold_byte", out_byte, 8'hAB);
         check("t2_in_ready", in_ready, 0);
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("t2_release_byte", out_byte, 8'hAB);
      check("t2_release_in_ready", in_ready, 0);
      tick();
      @(negedge clk);
      check("t2_lo_byte", out_byte, 8'hCD);
      check("t2_lo_last", out_last, 1);
      drain();

      // T3 back-to-back: second word accepted in the LO cycle of the first
      pop_cyc.delete();
      out_ready = 1'b1;
      send_word(32'h1122_0000, 8'h11, 8'h22, 1'b0, w);
      send_word(32'h3344_0000, 8'h33, 8'h44, 1'b0, w2);
      check("t3_wait_cycles", w2, 1);
      drain();
      check("t3_pop_count", pop_cyc.size(), 4);
      for (int i = 0; i + 1 < pop_cyc.size(); i++)
         check("t3_consecutive", pop_cyc[i+1] - pop_cyc[i], 1);

      // Table-driven words under random backpressure
      do_reset();
      bp_rand = 1'b1;
      for (int i = 0; i < 8; i++)
         send_word(vecs[i].word, vecs[i].hi, vecs[i].lo, vecs[i].bad, w);
      drain();

      // T4 wrap on the CNT_W=2 instance
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send_word(32'h0101_0000 * (i + 1), 8'(i + 1), 8'(i + 1), 1'b0, w);
         drain();
         check("t4_wrap_seq", w_word_cnt, wrap_seq[i]);
      end

      // T5 reset while in HI discards the held word
      do_reset();
      out_ready = 1'b0;
      send_word(32'h5566_0000, 8'h55, 8'h66, 1'b0, w);
      rst       = 1'b1;
      out_ready = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("t5_out_valid", out_valid, 0);
      check("t5_word_cnt", word_cnt, 0);
      check("t5_out_byte", out_byte, 0);
      check("t5_in_ready", in_ready, 1);
      for (int i = 0; i < 4; i++) tick();
      drain();

      // T6 zero-field check
      do_reset();
      out_ready = 1'b1;
      send_word(32'h1020_0001, 8'h10, 8'h20, 1'b1, w);
      drain();
      check("t6_zero_err_first", zero_err, ZCHK);
      check("t6_word_cnt_first", word_cnt, ZCHK ? 0 : 1);
      send_word(32'h3040_0000, 8'h30, 8'h40, 1'b0, w);
      drain();
      check("t6_zero_err_sticky", zero_err, ZCHK);
      check("t6_word_cnt_second", word_cnt, ZCHK ? 1 : 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete, required finish before 500000");
      $fatal(1, "timeout");
   end

endmodule
